hd_result_collector: RTL and testbench

HD_RESULT_COLLECTOR -- requirements
Module: hd_result_collector

---
 rtl/hd_result_collector.sv | 109 ++++++++++
 tb/tb_hd_result_collector.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hd_result_collector.sv
// Result collector: turns each rising edge of the classifier's done level into one
// FIFO entry tagged with a correctness bit, and keeps running accuracy counters.
module hd_result_collector #(
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     done_in,
  input  logic [15:0]              max_val_in,
  input  logic [15:0]              max_index_in,
  input  logic [15:0]              label_in,
  input  logic                     label_valid_in,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [15:0]              out_index,
  output logic [15:0]              out_val,
  output logic                     out_correct,
  output logic [CNT_WIDTH-1:0]     sample_count,
  output logic [CNT_WIDTH-1:0]     correct_count,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]        FULL_LVL = LW'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [15:0]   mem_index [DEPTH];
  logic [15:0]   mem_val   [DEPTH];
  logic          mem_corr  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          done_q;
  logic [15:0]   label_q;
  logic          label_pending;

  logic          evt;
  logic          label_avail;
  logic [15:0]   label_use;
  logic          correct;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  // Output handshake: the head entry transfers on any cycle where out_valid and
  // out_ready are both high; out_valid never depends on out_ready, and the head
  // stays stable until it is taken.
  assign evt         = done_in & ~done_q;
  assign label_avail = label_valid_in | label_pending;
  assign label_use   = label_valid_in ? label_in : label_q;
  assign correct     = label_avail && (max_index_in == label_use);
  assign full        = (fifo_level == FULL_LVL);
  assign out_valid   = (fifo_level != '0);
  assign pop         = out_valid & out_ready;
  assign push        = evt & (~full | pop);
  assign drop        = evt & full & ~pop;

  // Head is read straight from storage (fall-through) and forced to zero when empty.
  assign out_index   = out_valid ? mem_index[rd_ptr] : 16'h0000;
  assign out_val     = out_valid ? mem_val[rd_ptr]   : 16'h0000;
  assign out_correct = out_valid ? mem_corr[rd_ptr]  : 1'b0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_index[wr_ptr] <= max_index_in;
      mem_val[wr_ptr]   <= max_val_in;
      mem_corr[wr_ptr]  <= correct;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q        <= 1'b1;
      label_q       <= 16'h0000;
      label_pending <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      sample_count  <= '0;
      correct_count <= '0;
      overflow      <= 1'b0;
    end else begin
      done_q <= done_in;
      if (label_valid_in) label_q <= label_in;
      // An event consumes whatever label it used, including a same-cycle bypass.
      if (evt)                 label_pending <= 1'b0;
      else if (label_valid_in) label_pending <= 1'b1;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase

      if (push && sample_count != CNT_MAX)
        sample_count <= sample_count + CNT_WIDTH'(1);
      if (push && correct && correct_count != CNT_MAX)
        correct_count <= correct_count + CNT_WIDTH'(1);
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hd_result_collector.sv
// Directed bench for hd_result_collector with an expected-entry queue for the FIFO.
module tb_hd_result_collector;

  localparam int DEPTH     = 8;
  localparam int CNT_WIDTH = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 done_in;
  logic [15:0]          max_val_in;
  logic [15:0]          max_index_in;
  logic [15:0]          label_in;
  logic                 label_valid_in;
  logic                 out_ready;
  logic                 out_valid;
  logic [15:0]          out_index;
  logic [15:0]          out_val;
  logic                 out_correct;
  logic [CNT_WIDTH-1:0] sample_count;
  logic [CNT_WIDTH-1:0] correct_count;
  logic [3:0]           fifo_level;
  logic                 overflow;

  logic [32:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_samp = 0;
  int exp_corr = 0;
  logic exp_ovf = 1'b0;

  hd_result_collector #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .reset(reset), .done_in(done_in), .max_val_in(max_val_in),
    .max_index_in(max_index_in), .label_in(label_in), .label_valid_in(label_valid_in),
    .out_ready(out_ready), .out_valid(out_valid), .out_index(out_index),
    .out_val(out_val), .out_correct(out_correct), .sample_count(sample_count),
    .correct_count(correct_count), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed no finish required finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_level"}, 32'(fifo_level), 32'(exp_q.size()));
    chk({tag, "_samples"}, 32'(sample_count), 32'(exp_samp));
    chk({tag, "_correct"}, 32'(correct_count), 32'(exp_corr));
    chk({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    exp_q.delete();
    exp_samp = 0;
    exp_corr = 0;
    exp_ovf  = 1'b0;
  endtask

  task automatic give_label(input logic [15:0] lbl);
    label_valid_in = 1'b1;
    label_in = lbl;
    step();
    label_valid_in = 1'b0;
  endtask

  // One done_in rising edge, held for 'hold' cycles, then released for one cycle.
  task automatic fire(input logic [15:0] idx, input logic [15:0] val, input logic corr,
                      input logic lv, input logic [15:0] lbl, input logic with_pop,
                      input int hold);
    logic [32:0] e;
    if (with_pop) begin
      e = exp_q.pop_front();
      chk("pop_head_valid", 32'(out_valid), 32'd1);
      chk("pop_head_index", 32'(out_index), 32'(e[32:17]));
      out_ready = 1'b1;
    end
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back({idx, val, corr});
      if (exp_samp < 65535) exp_samp++;
      if (corr && exp_corr < 65535) exp_corr++;
    end else begin
      exp_ovf = 1'b1;
    end
    done_in = 1'b1;
    max_index_in = idx;
    max_val_in = val;
    label_valid_in = lv;
    label_in = lbl;
    step();
    out_ready = 1'b0;
    label_valid_in = 1'b0;
    for (int i = 1; i < hold; i++) step();
    done_in = 1'b0;
    step();
  endtask

  task automatic drain();
    logic [32:0] e;
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && n < 2 * DEPTH + 4) begin
      e = exp_q.pop_front();
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_index", 32'(out_index), 32'(e[32:17]));
      chk("drain_val", 32'(out_val), 32'(e[16:1]));
      chk("drain_correct", 32'(out_correct), 32'(e[0]));
      step();
      n++;
    end
    out_ready = 1'b0;
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_index_zero", 32'(out_index), 32'd0);
    chk("drain_level_zero", 32'(fifo_level), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    done_in = 1'b0;
    max_val_in = '0;
    max_index_in = '0;
    label_in = '0;
    label_valid_in = 1'b0;
    out_ready = 1'b0;
    do_reset();
    step();

    // Reset state
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_index", 32'(out_index), 32'd0);
    chk("rst_val", 32'(out_val), 32'd0);
    chk("rst_corr", 32'(out_correct), 32'd0);
    chk_counts("rst");

    // Pending label matches predicted index
    give_label(16'd5);
    fire(16'd5, 16'h0123, 1'b1, 1'b0, 16'd0, 1'b0, 1);
    chk("lbl5_valid", 32'(out_valid), 32'd1);
    chk("lbl5_index", 32'(out_index), 32'd5);
    chk("lbl5_val", 32'(out_val), 32'h0123);
    chk("lbl5_corr", 32'(out_correct), 32'd1);
    chk_counts("lbl5");
    drain();

    // Held done_in gives exactly one event; mismatch is incorrect
    give_label(16'd3);
    fire(16'd4, 16'h0BEE, 1'b0, 1'b0, 16'd0, 1'b0, 10);
    chk("hold_corr", 32'(out_correct), 32'd0);
    chk_counts("hold");
    drain();

    // Same-cycle label bypass, then the label is consumed
    fire(16'd7, 16'h0777, 1'b1, 1'b1, 16'd7, 1'b0, 1);
    fire(16'd7, 16'h0778, 1'b0, 1'b0, 16'd0, 1'b0, 1);
    chk_counts("bypass");
    drain();

    // Later label overwrites an earlier pending one
    give_label(16'd2);
    give_label(16'd9);
    fire(16'd9, 16'h0009, 1'b1, 1'b0, 16'd0, 1'b0, 1);
    give_label(16'd2);
    give_label(16'd9);
    fire(16'd2, 16'h0002, 1'b0, 1'b0, 16'd0, 1'b0, 1);
    chk_counts("overwrite");
    drain();

    // Nine events into a depth-8 FIFO with no consumer
    do_reset();
    step();
    for (int i = 0; i < 9; i++) begin
      if (i % 3 == 0) give_label(16'(i + 1));
      fire(16'(i + 1), 16'($urandom_range(0, 65535)), (i % 3 == 0), 1'b0, 16'd0, 1'b0, 1);
    end
    chk("ovf_level", 32'(fifo_level), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk_counts("ovf");
    drain();
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO: event with simultaneous pop is accepted
    do_reset();
    step();
    for (int i = 0; i < 8; i++)
      fire(16'(16'h40 + i), 16'($urandom_range(0, 65535)), 1'b0, 1'b0, 16'd0, 1'b0, 1);
    give_label(16'h99);
    fire(16'h99, 16'hABCD, 1'b1, 1'b0, 16'd0, 1'b1, 1);
    chk("fullpop_level", 32'(fifo_level), 32'd8);
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    chk("fullpop_samples", 32'(sample_count), 32'd9);
    chk_counts("fullpop");
    drain();

    // Reset with entries queued and done_in rising in the same cycle
    for (int i = 0; i < 3; i++)
      fire(16'(16'h10 + i), 16'(16'h20 + i), 1'b0, 1'b0, 16'd0, 1'b0, 1);
    chk("pre_rst_level", 32'(fifo_level), 32'd3);
    reset = 1'b1;
    done_in = 1'b1;
    max_index_in = 16'h55;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_index", 32'(out_index), 32'd0);
    chk("mid_rst_val", 32'(out_val), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_samples", 32'(sample_count), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    exp_samp = 0;
    exp_corr = 0;
    exp_ovf = 1'b0;
    step();
    step();
    step();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk_counts("post_rst");
    done_in = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
